// File: rtl/branch_redirect_ctrl_if.sv
// Fetch-side redirect handshake and flush signals of branch_redirect_ctrl.
// master = redirect controller, slave = fetch/decode front end.
interface branch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_lane;
    logic            flush;
    logic            flush_lane;

    modport master (
        output redirect_valid,
        output redirect_pc,
        output redirect_lane,
        output flush,
        output flush_lane,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        input  redirect_lane,
        input  flush,
        input  flush_lane,
        output redirect_ready
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Turns execute-stage taken branches into a registered fetch redirect plus a timed flush.
// Optional macro BRANCH_STATS_EN adds saturating per-lane taken counters (taken_cntA/taken_cntB).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a taken branch; execute inputs are sampled
// REDIRECT | redirect_valid high, waiting for redirect_ready
// FLUSH    | flush held for FLUSH_CYCLES cycles, then pending entry or IDLE
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic                   ex_validA,
    input  logic                   branch_takenA,
    input  logic [XLEN-1:0]        targetA,
    input  logic                   ex_validB,
    input  logic                   branch_takenB,
    input  logic [XLEN-1:0]        targetB,
    branch_redirect_ctrl_if.master fetchIf,
    output logic                   ex_stall
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]            taken_cntA,
    output logic [31:0]            taken_cntB
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } stateT;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    stateT           state, stateNext;
    logic [XLEN-1:0] curPc, curPcNext;
    logic            curLane, curLaneNext;
    logic [XLEN-1:0] pendPc, pendPcNext;
    logic            pendV, pendVNext;
    logic [3:0]      flushCnt, flushCntNext;
    logic            redirectValid, redirectValidNext;
    logic            flushQ, flushNext;
    logic            flushLane, flushLaneNext;
    logic            stallQ, stallNext;

    logic takeA;
    logic takeB;
    logic captureA;
    logic captureB;

    assign takeA    = ex_validA & branch_takenA;
    assign takeB    = ex_validB & branch_takenB & ~mode;
    assign captureA = (state == IDLE) & takeA;
    assign captureB = (state == IDLE) & takeB;

    always_comb begin
        stateNext         = state;
        curPcNext         = curPc;
        curLaneNext       = curLane;
        pendPcNext        = pendPc;
        pendVNext         = pendV;
        flushCntNext      = flushCnt;
        redirectValidNext = redirectValid;
        flushNext         = flushQ;
        flushLaneNext     = flushLane;

        case (state)
            IDLE: begin
                if (takeA) begin
                    curPcNext   = targetA;
                    curLaneNext = 1'b0;
                    if (takeB) begin
                        // lane B waits behind lane A; its lane tag is implicitly 1
                        pendPcNext = targetB;
                        pendVNext  = 1'b1;
                    end
                end else if (takeB) begin
                    curPcNext   = targetB;
                    curLaneNext = 1'b1;
                end
                if (takeA || takeB) begin
                    stateNext         = REDIRECT;
                    redirectValidNext = 1'b1;
                end
            end
            REDIRECT: begin
                if (redirectValid && fetchIf.redirect_ready) begin
                    redirectValidNext = 1'b0;
                    flushNext         = 1'b1;
                    flushLaneNext     = curLane;
                    flushCntNext      = FLUSH_LAST;
                    stateNext         = FLUSH;
                end
            end
            FLUSH: begin
                if (flushCnt == 4'd0) begin
                    flushNext = 1'b0;
                    if (pendV) begin
                        curPcNext         = pendPc;
                        curLaneNext       = 1'b1;
                        pendVNext         = 1'b0;
                        redirectValidNext = 1'b1;
                        stateNext         = REDIRECT;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    flushCntNext = flushCnt - 4'd1;
                end
            end
            default: begin
                stateNext         = IDLE;
                redirectValidNext = 1'b0;
                flushNext         = 1'b0;
                pendVNext         = 1'b0;
            end
        endcase

        stallNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            curPc         <= '0;
            curLane       <= 1'b0;
            pendPc        <= '0;
            pendV         <= 1'b0;
            flushCnt      <= 4'd0;
            redirectValid <= 1'b0;
            flushQ        <= 1'b0;
            flushLane     <= 1'b0;
            stallQ        <= 1'b0;
        end else begin
            state         <= stateNext;
            curPc         <= curPcNext;
            curLane       <= curLaneNext;
            pendPc        <= pendPcNext;
            pendV         <= pendVNext;
            flushCnt      <= flushCntNext;
            redirectValid <= redirectValidNext;
            flushQ        <= flushNext;
            flushLane     <= flushLaneNext;
            stallQ        <= stallNext;
        end
    end

    assign fetchIf.redirect_valid = redirectValid;
    assign fetchIf.redirect_pc    = curPc;
    assign fetchIf.redirect_lane  = curLane;
    assign fetchIf.flush          = flushQ;
    assign fetchIf.flush_lane     = flushLane;
    assign ex_stall               = stallQ;

`ifdef BRANCH_STATS_EN
    logic [31:0] statCntA;
    logic [31:0] statCntB;

    // a buffered lane-B take is counted at capture time, not at delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statCntA <= 32'd0;
            statCntB <= 32'd0;
        end else begin
            if (captureA && (statCntA != 32'hFFFF_FFFF)) statCntA <= statCntA + 32'd1;
            if (captureB && (statCntB != 32'hFFFF_FFFF)) statCntB <= statCntB + 32'd1;
        end
    end

    assign taken_cntA = statCntA;
    assign taken_cntB = statCntB;
`else
    logic unusedCapture;
    assign unusedCapture = captureA ^ captureB;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; expected values are hand-computed per step.
// Stats checks compile only when BRANCH_STATS_EN is defined.
module tb_branch_redirect_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode;
    logic            ex_validA, branch_takenA, ex_validB, branch_takenB;
    logic [XLEN-1:0] targetA, targetB;
    logic            ex_stall;
`ifdef BRANCH_STATS_EN
    logic [31:0]     taken_cntA, taken_cntB;
`endif

    int nAsserts = 0;
    int nFails   = 0;

    branch_redirect_ctrl_if #(.XLEN(XLEN)) fetchBus ();

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .ex_validA    (ex_validA),
        .branch_takenA(branch_takenA),
        .targetA      (targetA),
        .ex_validB    (ex_validB),
        .branch_takenB(branch_takenB),
        .targetB      (targetB),
        .fetchIf      (fetchBus),
        .ex_stall     (ex_stall)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cntA   (taken_cntA),
        .taken_cntB   (taken_cntB)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ex_validA = 0; branch_takenA = 0; targetA = '0;
        ex_validB = 0; branch_takenB = 0; targetB = '0;
    endtask

    task automatic chkOut(input string tag, input logic v, input logic [31:0] pc, input logic ln,
                          input logic fl, input logic fll, input logic st);
        chk({tag, ".valid"}, 32'(fetchBus.redirect_valid), 32'(v));
        if (v) begin
            chk({tag, ".pc"},   fetchBus.redirect_pc,         pc);
            chk({tag, ".lane"}, 32'(fetchBus.redirect_lane), 32'(ln));
        end
        chk({tag, ".flush"}, 32'(fetchBus.flush), 32'(fl));
        if (fl) chk({tag, ".flushLane"}, 32'(fetchBus.flush_lane), 32'(fll));
        chk({tag, ".stall"}, 32'(ex_stall), 32'(st));
    endtask

`ifdef BRANCH_STATS_EN
    task automatic waitIdle(input string tag);
        int n = 0;
        while (ex_stall !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, ".idleTimeout"}, 32'(ex_stall), 32'd0);
    endtask
`endif

    initial begin
        rst_n = 0;
        mode  = 1;
        fetchBus.redirect_ready = 0;
        clearInputs();
        #12;
        chk("rst.valid", 32'(fetchBus.redirect_valid), 32'd0);
        chk("rst.pc",    fetchBus.redirect_pc,         32'd0);
        chk("rst.lane",  32'(fetchBus.redirect_lane), 32'd0);
        chk("rst.flush", 32'(fetchBus.flush),         32'd0);
        chk("rst.flushLane", 32'(fetchBus.flush_lane), 32'd0);
        chk("rst.stall", 32'(ex_stall),               32'd0);
        rst_n = 1;
        tick();

        // unified takeA, ready already high; ready while idle is harmless
        fetchBus.redirect_ready = 1;
        tick();
        chkOut("t1.idleReady", 0, 0, 0, 0, 0, 0);
        ex_validA = 1; branch_takenA = 1; targetA = 32'h0000_1000;
        tick(); clearInputs();
        chkOut("t1.c1", 1, 32'h1000, 0, 0, 0, 1);
        tick(); chkOut("t1.c2", 0, 0, 0, 1, 0, 1);
        tick(); chkOut("t1.c3", 0, 0, 0, 1, 0, 1);
        tick(); chkOut("t1.c4", 0, 0, 0, 0, 0, 0);

        // split mode, simultaneous A and B
        mode = 0;
        ex_validA = 1; branch_takenA = 1; targetA = 32'h2000;
        ex_validB = 1; branch_takenB = 1; targetB = 32'h3000;
        tick(); clearInputs();
        chkOut("t2.c1", 1, 32'h2000, 0, 0, 0, 1);
        tick(); chkOut("t2.c2", 0, 0, 0, 1, 0, 1);
        tick(); chkOut("t2.c3", 0, 0, 0, 1, 0, 1);
        tick(); chkOut("t2.c4", 1, 32'h3000, 1, 0, 0, 1);
        tick(); chkOut("t2.c5", 0, 0, 0, 1, 1, 1);
        tick(); chkOut("t2.c6", 0, 0, 0, 1, 1, 1);
        tick(); chkOut("t2.c7", 0, 0, 0, 0, 0, 0);

        // unified mode masks lane B; invalid/not-taken A never redirects
        mode = 1;
        ex_validB = 1; branch_takenB = 1; targetB = 32'h7000;
        ex_validA = 1; branch_takenA = 0; targetA = 32'h7100;
        tick(); chkOut("t3.c1", 0, 0, 0, 0, 0, 0);
        ex_validA = 0; branch_takenA = 1;
        tick(); chkOut("t3.c2", 0, 0, 0, 0, 0, 0);
        clearInputs();
        tick(); chkOut("t3.c3", 0, 0, 0, 0, 0, 0);

        // backpressure: ready low for 5 cycles, new takes ignored while stalled
        fetchBus.redirect_ready = 0;
        ex_validA = 1; branch_takenA = 1; targetA = 32'h4444_0000;
        tick();
        mode = 0;
        ex_validA = 1; branch_takenA = 1; targetA = 32'h9999_0000;
        ex_validB = 1; branch_takenB = 1; targetB = 32'h8888_0000;
        for (int i = 0; i < 5; i++) begin
            chkOut($sformatf("t4.hold%0d", i), 1, 32'h4444_0000, 0, 0, 0, 1);
            if (i < 4) tick();
        end
        fetchBus.redirect_ready = 1;
        tick(); chkOut("t4.flush1", 0, 0, 0, 1, 0, 1);
        clearInputs();
        tick(); chkOut("t4.flush2", 0, 0, 0, 1, 0, 1);
        tick(); chkOut("t4.idle", 0, 0, 0, 0, 0, 0);

        // reset during FLUSH with a pending B entry
        ex_validA = 1; branch_takenA = 1; targetA = 32'h5000;
        ex_validB = 1; branch_takenB = 1; targetB = 32'h6000;
        tick(); clearInputs();
        chkOut("t5.c1", 1, 32'h5000, 0, 0, 0, 1);
        tick(); chkOut("t5.c2", 0, 0, 0, 1, 0, 1);
        rst_n = 0;
        #1;
        chk("t5.rst.valid", 32'(fetchBus.redirect_valid), 32'd0);
        chk("t5.rst.pc",    fetchBus.redirect_pc,         32'd0);
        chk("t5.rst.flush", 32'(fetchBus.flush),         32'd0);
        chk("t5.rst.stall", 32'(ex_stall),               32'd0);
        #2;
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chkOut($sformatf("t5.after%0d", i), 0, 0, 0, 0, 0, 0);
        end

`ifdef BRANCH_STATS_EN
        // 3 A-takes and 2 B-takes in split mode
        mode = 0;
        rst_n = 0; #2; rst_n = 1;
        tick();
        chk("st.rstA", taken_cntA, 32'd0);
        chk("st.rstB", taken_cntB, 32'd0);
        for (int k = 0; k < 3; k++) begin
            ex_validA = 1; branch_takenA = 1; targetA = 32'h100 * (k + 1);
            if (k < 2) begin
                ex_validB = 1; branch_takenB = 1; targetB = 32'h1000 * (k + 1);
            end
            tick(); clearInputs();
            waitIdle($sformatf("st.take%0d", k));
        end
        chk("st.cntA", taken_cntA, 32'd3);
        chk("st.cntB", taken_cntB, 32'd2);
        @(negedge clk);
        force dut.statCntA = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.statCntA;
        tick();
        ex_validA = 1; branch_takenA = 1; targetA = 32'hABC0;
        tick(); clearInputs();
        waitIdle("st.sat");
        chk("st.satA", taken_cntA, 32'hFFFF_FFFF);
        chk("st.satB", taken_cntB, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
